// File: rtl/axi_wr_slave_pkg.sv
// Shared types and constants for the AXI write-channel slave memory.
// Response codes are ordered so that a numeric max yields the most severe one.
package axi_wr_slave_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_wr_slave_ram.sv
// Word memory with per-byte write enables and a registered debug read port.
// The memory array itself is not reset; only the debug read register is.
module axi_wr_slave_ram #(
  parameter int unsigned C_MEM_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic [$clog2(C_MEM_WORDS)-1:0] waddr,
  input  logic [3:0]                     wstrb,
  input  logic [31:0]                    wdata,
  input  logic [$clog2(C_MEM_WORDS)-1:0] dbg_addr,
  output logic [31:0]                    dbg_rdata
);

  logic [31:0] mem [C_MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read-before-write: a same-cycle write to dbg_addr is seen one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dbg_rdata <= '0;
    else     dbg_rdata <= mem[dbg_addr];
  end

endmodule

// File: rtl/axi_wr_slave_mem.sv
// AXI write-channel slave: one burst at a time into a byte-strobed word memory,
// reporting size/burst/decode/beat-count errors on BRESP.
module axi_wr_slave_mem
  import axi_wr_slave_pkg::*;
#(
  parameter int C_AXI_ID_WIDTH   = 10,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_LEN_WIDTH  = 8,
  parameter int C_AXI_STRB_WIDTH = 4,
  parameter int C_AXI_RESP_WIDTH = 2,
  parameter int C_MEM_WORDS      = 256
) (
  input  logic                           AXI_ACLK,
  input  logic                           AXI_ARESET,
  input  logic [C_AXI_ID_WIDTH-1:0]      AXI_AWID,
  input  logic [C_AXI_ADDR_WIDTH-1:0]    AXI_AWADDR,
  input  logic [C_AXI_LEN_WIDTH-1:0]     AXI_AWLEN,
  input  logic [2:0]                     AXI_AWSIZE,
  input  logic [1:0]                     AXI_AWBURST,
  input  logic                           AXI_AWVALID,
  output logic                           AXI_AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]    AXI_WDATA,
  input  logic [C_AXI_STRB_WIDTH-1:0]    AXI_WSTRB,
  input  logic                           AXI_WLAST,
  input  logic                           AXI_WVALID,
  output logic                           AXI_WREADY,
  output logic [C_AXI_ID_WIDTH-1:0]      AXI_BID,
  output logic [C_AXI_RESP_WIDTH-1:0]    AXI_BRESP,
  output logic                           AXI_BVALID,
  input  logic                           AXI_BREADY,
  input  logic [$clog2(C_MEM_WORDS)-1:0] dbg_addr,
  output logic [31:0]                    dbg_rdata,
  output logic [31:0]                    wr_beat_cnt,
  output logic [31:0]                    wr_txn_cnt
);

  localparam int PTR_W  = C_AXI_ADDR_WIDTH - 2;
  localparam int MEM_AW = $clog2(C_MEM_WORDS);

  state_e                     state, state_next;
  logic [PTR_W-1:0]           ptr;
  logic [C_AXI_LEN_WIDTH-1:0] awlen_q;
  logic [C_AXI_LEN_WIDTH-1:0] beat_idx;
  logic [1:0]                 burst_q;
  logic [1:0]                 status;
  logic [1:0]                 status_beat;
  logic                       in_range;
  logic                       overrun;
  logic                       mem_we;
  logic                       aw_hs, w_hs, b_hs;

  assign aw_hs     = AXI_AWVALID && AXI_AWREADY;
  assign w_hs      = AXI_WVALID && AXI_WREADY;
  assign b_hs      = AXI_BVALID && AXI_BREADY;
  assign AXI_BRESP = C_AXI_RESP_WIDTH'(status);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (aw_hs) state_next = DATA;
      DATA:    if (w_hs && AXI_WLAST) state_next = RESP;
      RESP:    if (b_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status folded with this beat's errors; the beat itself writes only if the
  // status before it permits, it is in range, and it is not past AWLEN.
  always_comb begin
    in_range    = ptr < PTR_W'(C_MEM_WORDS);
    overrun     = beat_idx > awlen_q;
    status_beat = status;
    if (!in_range) status_beat = resp_max(status_beat, RESP_DECERR);
    if (overrun || (AXI_WLAST && (beat_idx != awlen_q)))
      status_beat = resp_max(status_beat, RESP_SLVERR);
    mem_we = w_hs && (status != RESP_SLVERR) && in_range && !overrun;
  end

  // Readies are registered copies of the next state.
  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      state       <= IDLE;
      AXI_AWREADY <= 1'b0;
      AXI_WREADY  <= 1'b0;
      AXI_BVALID  <= 1'b0;
    end else begin
      state       <= state_next;
      AXI_AWREADY <= (state_next == IDLE);
      AXI_WREADY  <= (state_next == DATA);
      AXI_BVALID  <= (state_next == RESP);
    end
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      AXI_BID     <= '0;
      ptr         <= '0;
      awlen_q     <= '0;
      burst_q     <= '0;
      status      <= RESP_OKAY;
      beat_idx    <= '0;
      wr_beat_cnt <= '0;
      wr_txn_cnt  <= '0;
    end else begin
      if (aw_hs) begin
        AXI_BID  <= AXI_AWID;
        ptr      <= AXI_AWADDR[C_AXI_ADDR_WIDTH-1:2];
        awlen_q  <= AXI_AWLEN;
        burst_q  <= AXI_AWBURST;
        beat_idx <= '0;
        status   <= ((AXI_AWSIZE != 3'b010) || (AXI_AWBURST == BURST_WRAP) ||
                     (AXI_AWBURST == 2'b11)) ? RESP_SLVERR : RESP_OKAY;
      end
      if (w_hs) begin
        status      <= status_beat;
        wr_beat_cnt <= wr_beat_cnt + 32'd1;
        if (burst_q == BURST_INCR) ptr <= ptr + PTR_W'(1);
        if (beat_idx != '1) beat_idx <= beat_idx + C_AXI_LEN_WIDTH'(1);
      end
      if (b_hs) wr_txn_cnt <= wr_txn_cnt + 32'd1;
    end
  end

  axi_wr_slave_ram #(
    .C_MEM_WORDS(C_MEM_WORDS)
  ) u_ram (
    .clk      (AXI_ACLK),
    .rst      (AXI_ARESET),
    .we       (mem_we),
    .waddr    (ptr[MEM_AW-1:0]),
    .wstrb    (AXI_WSTRB),
    .wdata    (AXI_WDATA),
    .dbg_addr (dbg_addr),
    .dbg_rdata(dbg_rdata)
  );

endmodule

// File: tb/tb_axi_wr_slave_mem.sv
// Self-checking bench: transaction-level model of memory, counters, phase and
// response, compared every cycle, plus directed literal expectations.
module tb_axi_wr_slave_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  AXI_AWID;
  logic [31:0] AXI_AWADDR;
  logic [7:0]  AXI_AWLEN;
  logic [2:0]  AXI_AWSIZE;
  logic [1:0]  AXI_AWBURST;
  logic        AXI_AWVALID, AXI_AWREADY;
  logic [31:0] AXI_WDATA;
  logic [3:0]  AXI_WSTRB;
  logic        AXI_WLAST, AXI_WVALID, AXI_WREADY;
  logic [9:0]  AXI_BID;
  logic [1:0]  AXI_BRESP;
  logic        AXI_BVALID, AXI_BREADY;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_rdata, wr_beat_cnt, wr_txn_cnt;

  always #5 clk = ~clk;

  axi_wr_slave_mem #(
    .C_AXI_ID_WIDTH(10), .C_AXI_ADDR_WIDTH(32), .C_AXI_DATA_WIDTH(32),
    .C_AXI_LEN_WIDTH(8), .C_AXI_STRB_WIDTH(4), .C_AXI_RESP_WIDTH(2), .C_MEM_WORDS(256)
  ) dut (
    .AXI_ACLK(clk), .AXI_ARESET(rst),
    .AXI_AWID(AXI_AWID), .AXI_AWADDR(AXI_AWADDR), .AXI_AWLEN(AXI_AWLEN),
    .AXI_AWSIZE(AXI_AWSIZE), .AXI_AWBURST(AXI_AWBURST),
    .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WLAST(AXI_WLAST),
    .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
    .AXI_BID(AXI_BID), .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata),
    .wr_beat_cnt(wr_beat_cnt), .wr_txn_cnt(wr_txn_cnt)
  );

  int unsigned n_chk = 0, n_pass = 0;
  logic [31:0] mem_m [256];
  int unsigned exp_beats = 0, exp_txns = 0;
  int          phase = 0;        // 0 address, 1 data, 2 response
  bit          armed = 1'b0;
  logic [9:0]  exp_bid = '0;
  logic [1:0]  exp_bresp = '0;
  longint unsigned m_ptr;
  int unsigned m_idx, m_len;
  logic [1:0]  m_status, m_burst;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      chk("awready", AXI_AWREADY, phase == 0);
      chk("wready", AXI_WREADY, phase == 1);
      chk("bvalid", AXI_BVALID, phase == 2);
      chk("beat_cnt", wr_beat_cnt, exp_beats);
      chk("txn_cnt", wr_txn_cnt, exp_txns);
      if (phase == 2) begin
        chk("bresp", AXI_BRESP, exp_bresp);
        chk("bid", AXI_BID, exp_bid);
      end
    end
  end

  task automatic aw_send(input logic [9:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    AXI_AWID = id; AXI_AWADDR = addr; AXI_AWLEN = len; AXI_AWSIZE = size; AXI_AWBURST = burst;
    AXI_AWVALID = 1'b1;
    while (AXI_AWREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      chk("aw_timeout", 0, 1);
      AXI_AWVALID = 1'b0;
      return;
    end
    @(posedge clk);
    exp_bid  = id;
    m_ptr    = longint'(addr >> 2);
    m_len    = len;
    m_idx    = 0;
    m_burst  = burst;
    m_status = (size != 3'd2 || burst >= 2'd2) ? 2'b10 : 2'b00;
    phase    = 1;
    @(negedge clk);
    AXI_AWVALID = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input bit last);
    int n = 0;
    bit in_range, over;
    AXI_WDATA = data; AXI_WSTRB = strb; AXI_WLAST = last; AXI_WVALID = 1'b1;
    while (AXI_WREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      chk("w_timeout", 0, 1);
      AXI_WVALID = 1'b0;
      return;
    end
    @(posedge clk);
    in_range = m_ptr < 256;
    over     = m_idx > m_len;
    if (m_status != 2'b10 && in_range && !over)
      for (int b = 0; b < 4; b++)
        if (strb[b]) mem_m[int'(m_ptr)][8*b +: 8] = data[8*b +: 8];
    if (!in_range) m_status = worst(m_status, 2'b11);
    if (over || (last && m_idx != m_len)) m_status = worst(m_status, 2'b10);
    if (m_burst == 2'b01) m_ptr++;
    if (m_idx < 255) m_idx++;
    exp_beats++;
    if (last) begin
      exp_bresp = m_status;
      phase = 2;
    end
    @(negedge clk);
    AXI_WVALID = 1'b0;
    AXI_WLAST  = 1'b0;
  endtask

  task automatic b_take(input int delay, output logic [1:0] resp, output logic [9:0] id);
    int n = 0;
    resp = '0; id = '0;
    while (AXI_BVALID !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      chk("b_timeout", 0, 1);
      return;
    end
    resp = AXI_BRESP;
    id   = AXI_BID;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("bresp_hold", AXI_BRESP, resp);
      chk("bid_hold", AXI_BID, id);
      chk("awready_low", AXI_AWREADY, 0);
    end
    AXI_BREADY = 1'b1;
    @(posedge clk);
    exp_txns++;
    phase = 0;
    @(negedge clk);
    AXI_BREADY = 1'b0;
  endtask

  task automatic rd(input int idx, input logic [31:0] exp, input string name);
    dbg_addr = 8'(idx);
    @(posedge clk);
    @(negedge clk);
    chk(name, dbg_rdata, exp);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_awready", AXI_AWREADY, 0);
    chk("rst_wready", AXI_WREADY, 0);
    chk("rst_bvalid", AXI_BVALID, 0);
    chk("rst_bresp", AXI_BRESP, 0);
    chk("rst_bid", AXI_BID, 0);
    chk("rst_dbg", dbg_rdata, 0);
    chk("rst_beats", wr_beat_cnt, 0);
    chk("rst_txns", wr_txn_cnt, 0);
  endtask

  initial begin
    logic [1:0]  r;
    logic [9:0]  id;
    logic [31:0] base;
    int          len, nb, w;
    logic [1:0]  bt;
    logic [2:0]  sz;

    rst = 1'b1;
    AXI_AWID = '0; AXI_AWADDR = '0; AXI_AWLEN = '0; AXI_AWSIZE = 3'd2; AXI_AWBURST = 2'b01;
    AXI_AWVALID = 1'b0; AXI_WDATA = '0; AXI_WSTRB = '0; AXI_WLAST = 1'b0; AXI_WVALID = 1'b0;
    AXI_BREADY = 1'b0; dbg_addr = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    chk("awready_after_reset", AXI_AWREADY, 1);
    armed = 1'b1;

    // 4-beat INCR burst
    aw_send(10'h155, 32'h10, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) w_send(32'hA0 + 32'(i), 4'hF, i == 3);
    b_take(0, r, id);
    chk("t1_bresp", r, 2'b00);
    chk("t1_bid", id, 10'h155);
    for (int i = 0; i < 4; i++) rd(4 + i, 32'hA0 + 32'(i), "t1_mem");
    chk("t1_beats", wr_beat_cnt, 4);
    chk("t1_txns", wr_txn_cnt, 1);

    // Fill the whole memory with zeros (also a maximum-length burst)
    aw_send(10'd1, 32'h0, 8'd255, 3'd2, 2'b01);
    for (int i = 0; i < 256; i++) w_send(32'h0, 4'hF, i == 255);
    b_take(0, r, id);
    chk("fill_bresp", r, 2'b00);

    // Partial strobe over zero
    aw_send(10'd2, 32'h20, 8'd0, 3'd2, 2'b01);
    w_send(32'hFFFF_FFFF, 4'b0101, 1'b1);
    b_take(0, r, id);
    chk("t2_bresp", r, 2'b00);
    rd(8, 32'h00FF_00FF, "t2_mem");

    // Early WLAST
    aw_send(10'd3, 32'h30, 8'd2, 3'd2, 2'b01);
    w_send(32'h1, 4'hF, 1'b0);
    w_send(32'h2, 4'hF, 1'b1);
    b_take(0, r, id);
    chk("t3_bresp", r, 2'b10);

    // Missing WLAST: only the first two beats land
    aw_send(10'd4, 32'h60, 8'd1, 3'd2, 2'b01);
    w_send(32'h11, 4'hF, 1'b0);
    w_send(32'h22, 4'hF, 1'b0);
    w_send(32'h33, 4'hF, 1'b0);
    w_send(32'h44, 4'hF, 1'b1);
    b_take(0, r, id);
    chk("t3b_bresp", r, 2'b10);
    rd(24, 32'h11, "t3b_w24");
    rd(25, 32'h22, "t3b_w25");
    rd(26, 32'h0, "t3b_w26");
    rd(27, 32'h0, "t3b_w27");

    // Run off the end of memory
    aw_send(10'd5, 32'd255 * 4, 8'd1, 3'd2, 2'b01);
    w_send(32'hCAFE_F00D, 4'hF, 1'b0);
    w_send(32'hDEAD_BEEF, 4'hF, 1'b1);
    b_take(0, r, id);
    chk("dec_bresp", r, 2'b11);
    rd(255, 32'hCAFE_F00D, "dec_w255");
    rd(0, 32'h0, "dec_w0");

    // WRAP is rejected
    aw_send(10'd6, 32'h50, 8'd1, 3'd2, 2'b10);
    w_send(32'h1234_5678, 4'hF, 1'b0);
    w_send(32'h9ABC_DEF0, 4'hF, 1'b1);
    b_take(0, r, id);
    chk("wrap_bresp", r, 2'b10);
    rd(20, 32'h0, "wrap_w20");
    rd(21, 32'h0, "wrap_w21");

    // W offered while idle is ignored
    AXI_WDATA = 32'h7777_7777; AXI_WSTRB = 4'hF; AXI_WVALID = 1'b1;
    repeat (3) @(negedge clk);
    AXI_WVALID = 1'b0;

    // Back-pressure on B
    aw_send(10'h3AB, 32'h70, 8'd0, 3'd2, 2'b01);
    w_send(32'h0000_1234, 4'hF, 1'b1);
    b_take(5, r, id);
    chk("bp_bresp", r, 2'b00);
    chk("bp_bid", id, 10'h3AB);

    // Reset in the middle of a 4-beat burst
    aw_send(10'd8, 32'h40, 8'd3, 3'd2, 2'b01);
    w_send(32'h5A5A_0001, 4'hF, 1'b0);
    w_send(32'h5A5A_0002, 4'hF, 1'b0);
    armed = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    phase = 0; exp_beats = 0; exp_txns = 0;
    @(negedge clk);
    chk("awready_after_midreset", AXI_AWREADY, 1);
    armed = 1'b1;
    rd(16, 32'h5A5A_0001, "mid_w16");
    rd(17, 32'h5A5A_0002, "mid_w17");
    rd(18, 32'h0, "mid_w18");
    aw_send(10'd9, 32'h48, 8'd0, 3'd2, 2'b01);
    w_send(32'h0BAD_CAFE, 4'hF, 1'b1);
    b_take(0, r, id);
    chk("mid_new_bresp", r, 2'b00);
    rd(18, 32'h0BAD_CAFE, "mid_new_w18");

    // Randomised bursts against the model
    for (int t = 0; t < 40; t++) begin
      base = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(250, 255)) : 32'($urandom_range(0, 239));
      len  = $urandom_range(0, 7);
      sz   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      bt   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
      nb   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, len + 3) : len + 1;
      aw_send(10'($urandom), base << 2, 8'(len), sz, bt);
      for (int k = 0; k < nb; k++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        w_send($urandom, 4'($urandom), k == nb - 1);
      end
      b_take($urandom_range(0, 2), r, id);
      chk("rand_bresp", r, exp_bresp);
      for (int k = 0; k < nb; k++) begin
        w = int'(base) + ((bt == 2'b01) ? k : 0);
        if (w < 256) rd(w, mem_m[w], "rand_mem");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
